// File: rtl/qpu_ifu_flush_rsp_pkg.sv
// qpu_ifu_flush_rsp_pkg: shared PC width and PC type for the IFU flush/response block.
`default_nettype none

`ifndef QPU_PC_SIZE
`define QPU_PC_SIZE 32
`endif

package qpu_ifu_flush_rsp_pkg;

  localparam int PC_SIZE = `QPU_PC_SIZE;

  typedef logic [PC_SIZE-1:0] pc_t;

endpackage

`default_nettype wire

// File: rtl/qpu_ifu_flush_rsp.sv
// qpu_ifu_flush_rsp: single-outstanding fetch issue with flush redirect and
// discard of the response belonging to a flushed fetch.
`default_nettype none

module qpu_ifu_flush_rsp
  import qpu_ifu_flush_rsp_pkg::*;
#(
  parameter logic [`QPU_PC_SIZE-1:0] RESET_PC = '0,
  parameter logic [`QPU_PC_SIZE-1:0] PC_STEP  = `QPU_PC_SIZE'(4)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fetch_en,
  input  logic                    pipe_flush_req,
  output logic                    pipe_flush_ack,
  input  logic [`QPU_PC_SIZE-1:0] pipe_flush_add_op1,
  input  logic [`QPU_PC_SIZE-1:0] pipe_flush_add_op2,
  output logic                    ifu_req_valid,
  input  logic                    ifu_req_ready,
  output logic [`QPU_PC_SIZE-1:0] ifu_req_pc,
  input  logic                    ifu_rsp_valid,
  output logic                    ifu_rsp_ready,
  output logic                    ifu_rsp_drop
);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0] state;
  pc_t        pc;
  logic       osd;

  pc_t  flush_pc;
  logic in_fetch;
  logic req_hs;

  assign flush_pc = pipe_flush_add_op1 + pipe_flush_add_op2;
  assign in_fetch = (state == FETCH);

  // Outputs are gated by rst so nothing leaks while the registers are still being reset.
  assign ifu_req_valid  = ~rst & in_fetch & fetch_en & ~osd & ~pipe_flush_req;
  assign pipe_flush_ack = ~rst & in_fetch & pipe_flush_req;
  assign ifu_rsp_drop   = ~rst & ifu_rsp_valid & osd & (pipe_flush_ack | ~in_fetch);
  assign ifu_rsp_ready  = 1'b1;
  assign ifu_req_pc     = pc;

  assign req_hs = ifu_req_valid & ifu_req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
      osd   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (pipe_flush_req) begin
            pc <= flush_pc;
            // A fetch still in flight must have its response swallowed before refetching.
            if (osd && !ifu_rsp_valid) begin
              state <= DRAIN;
            end else begin
              osd <= 1'b0;
            end
          end else if (req_hs) begin
            pc  <= pc + PC_STEP;
            osd <= 1'b1;
          end else if (ifu_rsp_valid) begin
            osd <= 1'b0;
          end
        end
        DRAIN: begin
          if (ifu_rsp_valid) begin
            osd   <= 1'b0;
            state <= FETCH;
          end
        end
        default: begin
          state <= FETCH;
          osd   <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_qpu_ifu_flush_rsp.sv
// tb_qpu_ifu_flush_rsp: directed cycle-by-cycle vectors plus a long-drain sequence.
`default_nettype none

module tb_qpu_ifu_flush_rsp;
  import qpu_ifu_flush_rsp_pkg::*;

  logic clk;
  logic rst;
  logic fetch_en;
  logic pipe_flush_req;
  logic pipe_flush_ack;
  pc_t  pipe_flush_add_op1;
  pc_t  pipe_flush_add_op2;
  logic ifu_req_valid;
  logic ifu_req_ready;
  pc_t  ifu_req_pc;
  logic ifu_rsp_valid;
  logic ifu_rsp_ready;
  logic ifu_rsp_drop;

  int checks   = 0;
  int failures = 0;

  qpu_ifu_flush_rsp dut (
    .clk                (clk),
    .rst                (rst),
    .fetch_en           (fetch_en),
    .pipe_flush_req     (pipe_flush_req),
    .pipe_flush_ack     (pipe_flush_ack),
    .pipe_flush_add_op1 (pipe_flush_add_op1),
    .pipe_flush_add_op2 (pipe_flush_add_op2),
    .ifu_req_valid      (ifu_req_valid),
    .ifu_req_ready      (ifu_req_ready),
    .ifu_req_pc         (ifu_req_pc),
    .ifu_rsp_valid      (ifu_rsp_valid),
    .ifu_rsp_ready      (ifu_rsp_ready),
    .ifu_rsp_drop       (ifu_rsp_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst, en, fl;
    pc_t  op1, op2;
    logic rdy, rv;
    logic ack, rqv;
    pc_t  pc;
    logic drop;
    logic chk_pc;
  } vec_t;

  localparam int NV = 36;
  vec_t tv [NV];

  function automatic vec_t mk(logic r, logic e, logic f, pc_t a, pc_t b, logic rd, logic v,
                              logic ack, logic rqv, pc_t pc, logic drop, logic cpc);
    vec_t t;
    t.rst = r;  t.en = e;  t.fl = f;  t.op1 = a;  t.op2 = b;  t.rdy = rd;  t.rv = v;
    t.ack = ack; t.rqv = rqv; t.pc = pc; t.drop = drop; t.chk_pc = cpc;
    return t;
  endfunction

  task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=0x%0h expected=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic f, input pc_t a, input pc_t b,
                       input logic rd, input logic v);
    rst = r; fetch_en = e; pipe_flush_req = f;
    pipe_flush_add_op1 = a; pipe_flush_add_op2 = b;
    ifu_req_ready = rd; ifu_rsp_valid = v;
  endtask

  initial begin
    bit seen;

    //            rst en fl op1           op2     rdy rv   ack rqv pc           drop cpc
    tv[0]  = mk(1, 0, 0, 0,            0,      0,  0,   0,  0,  0,           0,   0);
    // sequential fetch with a response every other cycle
    tv[1]  = mk(0, 1, 0, 0,            0,      1,  0,   0,  1,  'h0,         0,   1);
    tv[2]  = mk(0, 1, 0, 0,            0,      1,  1,   0,  0,  'h4,         0,   1);
    tv[3]  = mk(0, 1, 0, 0,            0,      1,  0,   0,  1,  'h4,         0,   1);
    tv[4]  = mk(0, 1, 0, 0,            0,      1,  1,   0,  0,  'h8,         0,   1);
    tv[5]  = mk(0, 1, 0, 0,            0,      1,  0,   0,  1,  'h8,         0,   1);
    tv[6]  = mk(0, 1, 0, 0,            0,      1,  1,   0,  0,  'hc,         0,   1);
    // flush with nothing outstanding
    tv[7]  = mk(0, 1, 1, 'h100,        'h20,   1,  0,   1,  0,  'hc,         0,   1);
    tv[8]  = mk(0, 1, 0, 0,            0,      1,  0,   0,  1,  'h120,       0,   1);
    // flush with fetch outstanding, response three cycles later
    tv[9]  = mk(0, 1, 1, 'h40,         'h8,    1,  0,   1,  0,  'h124,       0,   1);
    tv[10] = mk(0, 1, 0, 0,            0,      1,  0,   0,  0,  'h48,        0,   1);
    tv[11] = mk(0, 1, 0, 0,            0,      1,  0,   0,  0,  'h48,        0,   1);
    tv[12] = mk(0, 1, 0, 0,            0,      1,  1,   0,  0,  'h48,        1,   1);
    tv[13] = mk(0, 1, 0, 0,            0,      1,  0,   0,  1,  'h48,        0,   1);
    // flush and response in the same cycle
    tv[14] = mk(0, 1, 1, 'h200,        'h4,    1,  1,   1,  0,  'h4c,        1,   1);
    tv[15] = mk(0, 1, 0, 0,            0,      0,  0,   0,  1,  'h204,       0,   1);
    tv[16] = mk(0, 1, 0, 0,            0,      1,  0,   0,  1,  'h204,       0,   1);
    tv[17] = mk(0, 1, 0, 0,            0,      1,  1,   0,  0,  'h208,       0,   1);
    // flush adder carry discarded
    tv[18] = mk(0, 1, 1, 'hffffffff,   'h2,    1,  0,   1,  0,  'h208,       0,   1);
    tv[19] = mk(0, 1, 0, 0,            0,      1,  0,   0,  1,  'h1,         0,   1);
    tv[20] = mk(0, 1, 0, 0,            0,      1,  1,   0,  0,  'h5,         0,   1);
    // sequential increment wraps
    tv[21] = mk(0, 1, 1, 'hfffffff0,   'hc,    1,  0,   1,  0,  'h5,         0,   1);
    tv[22] = mk(0, 1, 0, 0,            0,      1,  0,   0,  1,  'hfffffffc,  0,   1);
    tv[23] = mk(0, 1, 0, 0,            0,      1,  1,   0,  0,  'h0,         0,   1);
    // fetch disabled does not block flush
    tv[24] = mk(0, 0, 1, 'h300,        'h0,    1,  0,   1,  0,  'h0,         0,   1);
    tv[25] = mk(0, 0, 0, 0,            0,      1,  0,   0,  0,  'h300,       0,   1);
    tv[26] = mk(0, 1, 0, 0,            0,      1,  0,   0,  1,  'h300,       0,   1);
    // second flush waits out DRAIN, then wins
    tv[27] = mk(0, 1, 1, 'h500,        'h0,    1,  0,   1,  0,  'h304,       0,   1);
    tv[28] = mk(0, 1, 1, 'h600,        'h0,    1,  0,   0,  0,  'h500,       0,   1);
    tv[29] = mk(0, 1, 1, 'h600,        'h0,    1,  1,   0,  0,  'h500,       1,   1);
    tv[30] = mk(0, 1, 1, 'h600,        'h0,    1,  0,   1,  0,  'h500,       0,   1);
    tv[31] = mk(0, 1, 0, 0,            0,      1,  0,   0,  1,  'h600,       0,   1);
    // reset during DRAIN, stale response afterwards
    tv[32] = mk(0, 1, 1, 'h700,        'h0,    1,  0,   1,  0,  'h604,       0,   1);
    tv[33] = mk(1, 1, 1, 'h700,        'h0,    1,  1,   0,  0,  0,           0,   0);
    tv[34] = mk(0, 0, 0, 0,            0,      1,  1,   0,  0,  'h0,         0,   1);
    tv[35] = mk(0, 1, 0, 0,            0,      1,  0,   0,  1,  'h0,         0,   1);

    drive(1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tv[i].rst, tv[i].en, tv[i].fl, tv[i].op1, tv[i].op2, tv[i].rdy, tv[i].rv);
      #2;
      check("flush_ack", i, 64'(pipe_flush_ack), 64'(tv[i].ack));
      check("req_valid", i, 64'(ifu_req_valid), 64'(tv[i].rqv));
      check("rsp_drop",  i, 64'(ifu_rsp_drop),  64'(tv[i].drop));
      check("rsp_ready", i, 64'(ifu_rsp_ready), 64'd1);
      if (tv[i].chk_pc) check("req_pc", i, 64'(ifu_req_pc), 64'(tv[i].pc));
    end

    // Long drain: fetch at pc 0 is outstanding (pc now 4); flush to 0x80.
    @(negedge clk);
    drive(0, 1, 1, 'h80, 'h0, 1, 0);
    #2;
    check("long_ack", 100, 64'(pipe_flush_ack), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(0, 1, 0, 0, 0, 1, 0);
      #2;
      check("long_drain_req", 101 + k, 64'(ifu_req_valid), 64'd0);
      check("long_drain_drop", 101 + k, 64'(ifu_rsp_drop), 64'd0);
    end
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 1, 1);
    #2;
    check("long_drop", 110, 64'(ifu_rsp_drop), 64'd1);
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 1, 0);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      #2;
      if (ifu_req_valid) seen = 1;
      else @(negedge clk);
    end
    check("long_resume_seen", 111, 64'(seen), 64'd1);
    if (seen) check("long_resume_pc", 112, 64'(ifu_req_pc), 64'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/qpu_ifu_flush_rsp.md
QPU_IFU_FLUSH_RSP -- requirements
Module: QPU_ifu_flush_rsp

Interface
REQ-001 SHALL have parameter RESET_PC, default 0, meaning the PC loaded at reset.
REQ-002 SHALL have parameter PC_STEP, default 4, meaning the sequential fetch PC increment.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port fetch_en, input, 1 bit: enables sequential fetch issue.
REQ-006 SHALL have port pipe_flush_req, input, 1 bit: flush request from commit; held until acked.
REQ-007 SHALL have port pipe_flush_ack, output, 1 bit: flush accepted this cycle.
REQ-008 SHALL have ports pipe_flush_add_op1 and pipe_flush_add_op2, inputs, `QPU_PC_SIZE bits each: flush-target adder operands.
REQ-009 SHALL have port ifu_req_valid, output, 1 bit: fetch request valid.
REQ-010 SHALL have port ifu_req_ready, input, 1 bit: fetch request accepted by memory.
REQ-011 SHALL have port ifu_req_pc, output, `QPU_PC_SIZE bits: fetch address.
REQ-012 SHALL have port ifu_rsp_valid, input, 1 bit: fetch response returning.
REQ-013 SHALL have port ifu_rsp_ready, output, 1 bit: constant 1.
REQ-014 SHALL have port ifu_rsp_drop, output, 1 bit: current response belongs to a flushed fetch and is discarded.

Function
REQ-015 SHALL hold a PC register; ifu_req_pc = PC register.
REQ-016 SHALL track at most one outstanding fetch (osd flag): set on req handshake, cleared on ifu_rsp_valid.
REQ-017 SHALL implement FSM states FETCH and DRAIN.
REQ-018 In FETCH: ifu_req_valid = fetch_en & ~osd & ~pipe_flush_req; no request is issued in a cycle with a pending flush.
REQ-019 In FETCH, on a req handshake, PC SHALL update to PC + PC_STEP, wrapping modulo 2^`QPU_PC_SIZE.
REQ-020 In FETCH: pipe_flush_ack = pipe_flush_req, combinationally, same cycle.
REQ-021 On flush acceptance, PC SHALL load op1 + op2, truncated to `QPU_PC_SIZE bits (carry discarded).
REQ-022 Flush accepted with osd=0: stay in FETCH; first request from the new PC no earlier than the next cycle.
REQ-023 Flush accepted with osd=1 and ifu_rsp_valid=0: go to DRAIN.
REQ-024 Flush accepted with osd=1 and ifu_rsp_valid=1 in the same cycle: ifu_rsp_drop=1, osd cleared, stay in FETCH.
REQ-025 In DRAIN: ifu_req_valid=0 and pipe_flush_ack=0.
REQ-026 In DRAIN, ifu_rsp_valid SHALL assert ifu_rsp_drop, clear osd, and return the FSM to FETCH next cycle.
REQ-027 ifu_rsp_drop SHALL be 0 in all other cases.
REQ-028 A second flush arriving during DRAIN SHALL wait; it is acked in FETCH and overrides the PC.
REQ-029 fetch_en=0 SHALL not block flush acceptance or draining.

Reset
REQ-030 When rst=1, PC SHALL be RESET_PC, osd 0, FSM in FETCH, next cycle.
REQ-031 While rst=1: ifu_req_valid=0, pipe_flush_ack=0, ifu_rsp_drop=0.
REQ-032 Reset mid-DRAIN SHALL abandon the drain; a stale response after reset is ignored (osd=0, no drop).

Structure
REQ-033 SHALL take `QPU_PC_SIZE from QPU_defines.v; the FSM state encodings SHALL be local parameters.
REQ-034 SHALL be a single module with no sub-modules; the flush adder is local to this block.

Verification
REQ-035 Reset, fetch_en=1, ready=1, responses every cycle -> ifu_req_pc sequence 0, 4, 8 on alternating request cycles.
REQ-036 osd=0, flush op1=0x100, op2=0x20 -> ack the same cycle; next request pc=0x120.
REQ-037 osd=1, flush op1=0x40, op2=0x8, response 3 cycles later -> ack at cycle 0; DRAIN with no requests; drop=1 on the response; next request pc=0x48.
REQ-038 osd=1, flush and response in the same cycle -> ack=1, drop=1, no DRAIN entry; next request from the flush target.
REQ-039 op1=all-ones, op2=2 -> PC wraps to 1.
REQ-040 rst asserted during DRAIN, then a response arrives -> drop=0, PC=RESET_PC, fetch resumes from RESET_PC.
